// File: rtl/axi_lite_slv_mem_pkg.sv
// Shared types for the AXI4-Lite memory responder: response codes,
// write/read FSM state encodings and the address range helper.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_HAVE_A = 3'd1,
    W_HAVE_D = 3'd2,
    W_COMMIT = 3'd3,
    W_RESP   = 3'd4
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACCESS = 2'd1,
    R_RESP   = 2'd2
  } rd_state_t;

  // A word index addresses real storage only when it is below the depth.
  function automatic logic idx_in_range(input int unsigned idx, input int unsigned depth);
    return (idx < depth);
  endfunction

endpackage

// File: rtl/axi_lite_slv_mem_if.sv
// AXI4-Lite bus bundle between the master stimulus and the memory responder.
interface axi_lite_slv_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_slv_mem_ram.sv
// Synchronous word RAM with byte-enable writes and a registered read port.
// A read and a write to the same word on one edge return the old contents.
// Storage is deliberately not reset so contents survive a bus reset.
module axi_lite_slv_mem_ram #(
  parameter int DEPTH  = 1024,
  parameter int AW     = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write: each strobe bit updates its own 8-bit lane.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i && wstrb_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Registered read; non-blocking semantics give read-first on collision.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slv_mem.sv
// AXI4-Lite responder backed by a word-addressed internal RAM.
// Independent write and read FSMs, one outstanding transaction each.
module axi_lite_slv_mem
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic             clock,
  input  logic             reset,
  axi_lite_slv_mem_if.slave bus
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int STRB_W = DATA_W / 8;

  // Write path state
  wr_state_t          wr_state_q;
  logic               awready_q;
  logic               wready_q;
  logic               bvalid_q;
  resp_t              bresp_q;
  logic [IDX_W-1:0]   awidx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;

  // Read path state
  rd_state_t          rd_state_q;
  logic               arready_q;
  logic               rvalid_q;
  resp_t              rresp_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [IDX_W-1:0]   aridx_q;

  logic               aw_hs_s;
  logic               w_hs_s;
  logic               ar_hs_s;
  logic               aw_in_range_s;
  logic               ar_in_range_s;
  logic               ram_we_s;
  logic               ram_re_s;
  logic [DATA_W-1:0]  ram_rdata_s;
  logic               unused_addr_lsbs;

  // Byte offset within a word carries no meaning for a word memory.
  assign unused_addr_lsbs = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};

  assign aw_hs_s = bus.s_awvalid && awready_q;
  assign w_hs_s  = bus.s_wvalid  && wready_q;
  assign ar_hs_s = bus.s_arvalid && arready_q;

  assign aw_in_range_s = idx_in_range(32'(awidx_q), $unsigned(MEM_DEPTH));
  assign ar_in_range_s = idx_in_range(32'(aridx_q), $unsigned(MEM_DEPTH));

  // RAM write only on the commit edge and only for a valid index.
  assign ram_we_s = (wr_state_q == W_COMMIT) && aw_in_range_s;
  assign ram_re_s = (rd_state_q == R_ACCESS);

  axi_lite_slv_mem_ram #(
    .DEPTH  (MEM_DEPTH),
    .AW     (MEM_AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we_s),
    .waddr_i (awidx_q[MEM_AW-1:0]),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .re_i    (ram_re_s),
    .raddr_i (aridx_q[MEM_AW-1:0]),
    .rdata_o (ram_rdata_s)
  );

  // Write FSM: gather AW and W in any order, commit, then hold B until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs_s) begin
            awidx_q <= bus.s_awaddr[ADDR_W-1:2];
          end
          if (w_hs_s) begin
            wdata_q <= bus.s_wdata;
            wstrb_q <= bus.s_wstrb;
          end
          if (aw_hs_s && w_hs_s) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_state_q <= W_COMMIT;
          end else if (aw_hs_s) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_HAVE_A;
          end else if (w_hs_s) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            wr_state_q <= W_HAVE_D;
          end else begin
            // Also the path that raises both readies after reset release.
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_HAVE_A: begin
          if (w_hs_s) begin
            wdata_q    <= bus.s_wdata;
            wstrb_q    <= bus.s_wstrb;
            wready_q   <= 1'b0;
            wr_state_q <= W_COMMIT;
          end
        end
        W_HAVE_D: begin
          if (aw_hs_s) begin
            awidx_q    <= bus.s_awaddr[ADDR_W-1:2];
            awready_q  <= 1'b0;
            wr_state_q <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          bvalid_q   <= 1'b1;
          bresp_q    <= aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
          wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: capture AR, read the RAM one edge later, present R the edge after.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      aridx_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs_s) begin
            aridx_q    <= bus.s_araddr[ADDR_W-1:2];
            arready_q  <= 1'b0;
            rd_state_q <= R_ACCESS;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_ACCESS: begin
          rd_state_q <= R_RESP;
        end
        R_RESP: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= ar_in_range_s ? ram_rdata_s : '0;
          end else if (bus.s_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: begin
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign bus.s_awready = awready_q;
  assign bus.s_wready  = wready_q;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = bresp_q;
  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_slv_mem.sv
// Directed bench for axi_lite_slv_mem: a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_axi_lite_slv_mem;

  logic clock;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  axi_lite_slv_mem_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  axi_lite_slv_mem #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .MEM_DEPTH (1024)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input string tag);
    logic aw_done, w_done, a_rdy, w_rdy;
    int   n;
    bus.s_awaddr  = a;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = d;
    bus.s_wstrb   = s;
    bus.s_wvalid  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      a_rdy = bus.s_awready;
      w_rdy = bus.s_wready;
      tick();
      if (a_rdy && bus.s_awvalid) begin aw_done = 1'b1; bus.s_awvalid = 1'b0; end
      if (w_rdy && bus.s_wvalid)  begin w_done  = 1'b1; bus.s_wvalid  = 1'b0; end
      n++;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    check({tag, "_hs"}, {31'b0, aw_done && w_done}, 32'd1);
    check({tag, "_bvalid_early"}, {31'b0, bus.s_bvalid}, 32'd0);
    tick();
    check({tag, "_bvalid"}, {31'b0, bus.s_bvalid}, 32'd1);
    check({tag, "_bresp"}, {30'b0, bus.s_bresp}, {30'b0, exp_resp});
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    check({tag, "_bclr"}, {31'b0, bus.s_bvalid}, 32'd0);
    check({tag, "_awrdy"}, {31'b0, bus.s_awready}, 32'd1);
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    logic done, r_rdy;
    int   n;
    bus.s_araddr  = a;
    bus.s_arvalid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      r_rdy = bus.s_arready;
      tick();
      if (r_rdy) begin done = 1'b1; bus.s_arvalid = 1'b0; end
      n++;
    end
    bus.s_arvalid = 1'b0;
    check({tag, "_hs"}, {31'b0, done}, 32'd1);
    tick();
    check({tag, "_rvalid_early"}, {31'b0, bus.s_rvalid}, 32'd0);
    tick();
    check({tag, "_rvalid"}, {31'b0, bus.s_rvalid}, 32'd1);
    check({tag, "_rresp"}, {30'b0, bus.s_rresp}, {30'b0, exp_resp});
    check({tag, "_rdata"}, bus.s_rdata, exp_data);
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    check({tag, "_rclr"}, {31'b0, bus.s_rvalid}, 32'd0);
    check({tag, "_arrdy"}, {31'b0, bus.s_arready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset = 1'b1;
    bus.s_awaddr = 16'h0000; bus.s_awvalid = 1'b0;
    bus.s_wdata  = 32'h0;    bus.s_wstrb   = 4'h0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = 16'h0000; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;

    vecs[0]  = '{1'b1, 16'h0012, 32'h00001234, 4'h3, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'hDEAD1234};
    vecs[2]  = '{1'b1, 16'h0000, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 16'h1000, 32'h11111111, 4'hF, 2'b10, 32'h0};
    vecs[4]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 2'b10, 32'h00000000};
    vecs[5]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[6]  = '{1'b1, 16'h0004, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 16'h0004, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 16'h0007, 32'h11223344, 4'hA, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h11A533A5};
    vecs[11] = '{1'b1, 16'h0FFC, 32'h55AA55AA, 4'hF, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 16'h0FFF, 32'h0,        4'h0, 2'b00, 32'h55AA55AA};
    vecs[13] = '{1'b0, 16'hFFFC, 32'h0,        4'h0, 2'b10, 32'h00000000};

    // Reset state and release
    repeat (3) tick();
    check("rst_awready", {31'b0, bus.s_awready}, 32'd0);
    check("rst_wready",  {31'b0, bus.s_wready},  32'd0);
    check("rst_arready", {31'b0, bus.s_arready}, 32'd0);
    check("rst_bvalid",  {31'b0, bus.s_bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, bus.s_rvalid},  32'd0);
    check("rst_rdata",   bus.s_rdata, 32'h0);
    check("rst_resps",   {28'b0, bus.s_bresp, bus.s_rresp}, 32'h0);
    reset = 1'b0;
    check("rel_pre_awready", {31'b0, bus.s_awready}, 32'd0);
    tick();
    check("rel_readies", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h7);
    check("rel_valids",  {30'b0, bus.s_bvalid, bus.s_rvalid}, 32'h0);

    // AW first, W three cycles later
    bus.s_awaddr = 16'h0010; bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    check("t2_have_a_rdy", {30'b0, bus.s_awready, bus.s_wready}, 32'h1);
    repeat (2) tick();
    check("t2_hold_rdy", {30'b0, bus.s_awready, bus.s_wready}, 32'h1);
    check("t2_hold_bvalid", {31'b0, bus.s_bvalid}, 32'd0);
    bus.s_wdata = 32'hDEADBEEF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    check("t2_commit_rdy", {30'b0, bus.s_awready, bus.s_wready}, 32'h0);
    check("t2_bvalid_early", {31'b0, bus.s_bvalid}, 32'd0);
    tick();
    check("t2_bvalid", {31'b0, bus.s_bvalid}, 32'd1);
    check("t2_bresp", {30'b0, bus.s_bresp}, 32'd0);
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    check("t2_bclr_rdy", {29'b0, bus.s_bvalid, bus.s_awready, bus.s_wready}, 32'h3);
    axi_read(16'h0010, 32'hDEADBEEF, 2'b00, "t2_rd");

    // Table of single transactions
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr)
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, $sformatf("v%0d_wr", i));
      else
        axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp, $sformatf("v%0d_rd", i));
    end

    // B back-pressure blocks a second AW
    bus.s_awaddr = 16'h0008; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h01020304; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    tick();
    check("t5_bvalid", {31'b0, bus.s_bvalid}, 32'd1);
    bus.s_awaddr = 16'h000C; bus.s_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_stall%0d", i), {29'b0, bus.s_bvalid, bus.s_awready, bus.s_wready}, 32'h4);
    end
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    check("t5_after_b", {30'b0, bus.s_bvalid, bus.s_awready}, 32'h1);
    tick();
    bus.s_awvalid = 1'b0;
    check("t5_aw2_taken", {30'b0, bus.s_awready, bus.s_wready}, 32'h1);
    bus.s_wdata = 32'h0000BEEF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    tick();
    check("t5_b2", {29'b0, bus.s_bvalid, bus.s_bresp}, 32'h4);
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    axi_read(16'h000C, 32'h0000BEEF, 2'b00, "t5_rd_c");
    axi_read(16'h0008, 32'h01020304, 2'b00, "t5_rd_8");

    // AW, W and AR together on one word: read sees pre-commit data
    axi_write(16'h0020, 32'h0BAD0001, 4'hF, 2'b00, "col_init");
    bus.s_awaddr = 16'h0020; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h600D0002; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    bus.s_araddr = 16'h0020; bus.s_arvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    check("col_all_taken", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h0);
    tick();
    check("col_n1", {30'b0, bus.s_bvalid, bus.s_rvalid}, 32'h2);
    tick();
    check("col_n2", {30'b0, bus.s_bvalid, bus.s_rvalid}, 32'h3);
    check("col_old_data", bus.s_rdata, 32'h0BAD0001);
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    tick();
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    check("col_clr", {30'b0, bus.s_bvalid, bus.s_rvalid}, 32'h0);
    axi_read(16'h0020, 32'h600D0002, 2'b00, "col_new");

    // Reset while R is pending; memory must survive
    bus.s_araddr = 16'h0010; bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    repeat (2) tick();
    check("t6_rvalid", {31'b0, bus.s_rvalid}, 32'd1);
    tick();
    check("t6_rvalid_held", {31'b0, bus.s_rvalid}, 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_rvalid", {31'b0, bus.s_rvalid}, 32'd0);
    check("t6_rst_rdy", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h0);
    check("t6_rst_rdata", bus.s_rdata, 32'h0);
    reset = 1'b0;
    tick();
    check("t6_rel_rdy", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h7);
    axi_read(16'h0010, 32'hDEAD1234, 2'b00, "t6_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
